// File: rtl/usp_pkg.sv
// Shared types and arithmetic helpers for the up-sampling interpolator and its
// decimating sibling in the filter chain.
package usp_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Wide enough for any accumulator this filter family uses.
    localparam int SAT_W = 64;

    function automatic int calc_tpp(input int ncoeffs, input int up_factor);
        calc_tpp = ncoeffs / up_factor;
    endfunction

    function automatic int calc_acc_w(input int in_w, input int coeff_w, input int tpp);
        calc_acc_w = in_w + coeff_w + $clog2(tpp);
    endfunction

    // Round half up at the binary point, then clamp to the signed out_w range.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac_bits,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] rnd;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        rnd = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        if (rnd > hi) begin
            sat_round = hi;
        end else if (rnd < lo) begin
            sat_round = lo;
        end else begin
            sat_round = rnd;
        end
    endfunction

endpackage

// File: rtl/usp_mac.sv
// Two-stage multiply-accumulate: registered product, then accumulate. The
// running sum restarts on the first tap of a phase; the final sum is exposed
// combinationally together with a strobe on the last tap.
module usp_mac #(
    parameter int A_W   = 24,
    parameter int B_W   = 16,
    parameter int ACC_W = 44
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    vld_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    sum_vld_o
);

    localparam int PROD_W = A_W + B_W;

    logic signed [PROD_W-1:0] prod_q;
    logic                     vld1_q;
    logic                     first1_q;
    logic                     last1_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Stage 1: product register with its tap tags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prod_q   <= '0;
            vld1_q   <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
        end else begin
            prod_q   <= a_i * b_i;
            vld1_q   <= vld_i;
            first1_q <= first_i;
            last1_q  <= last_i;
        end
    end

    // Stage 2: next accumulator value.
    always_comb begin
        acc_d = acc_q;
        if (vld1_q) begin
            if (first1_q) begin
                acc_d = ACC_W'(prod_q);
            end else begin
                acc_d = acc_q + ACC_W'(prod_q);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum_o     = acc_d;
    assign sum_vld_o = vld1_q & last1_q;

endmodule

// File: rtl/usp_interp.sv
// Polyphase FIR interpolator: one input sample yields UP_FACTOR outputs, each
// phase computed over TPP taps with a single shared MAC.
module usp_interp
    import usp_pkg::*;
#(
    parameter int    IN_WIDTH       = 24,
    parameter int    OUT_WIDTH      = IN_WIDTH,
    parameter int    COEFF_W        = 16,
    parameter int    NCOEFFS        = 64,
    parameter int    UP_FACTOR      = 4,
    parameter bit    FIXED_COEFFS   = 1'b0,
    parameter string INITIAL_COEFFS = ""
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tap_wr,
    input  logic [COEFF_W-1:0]   i_tap,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_WIDTH-1:0]  i_sample,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_sample
);

    localparam int TPP   = calc_tpp(NCOEFFS, UP_FACTOR);
    localparam int TW    = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int CW    = (NCOEFFS > 1) ? $clog2(NCOEFFS) : 1;
    localparam int PW    = (UP_FACTOR > 1) ? $clog2(UP_FACTOR) : 1;
    localparam int ACC_W = calc_acc_w(IN_WIDTH, COEFF_W, TPP);

    if ((NCOEFFS % UP_FACTOR) != 0 || TPP < 2 || (TPP & (TPP - 1)) != 0) begin : g_bad_tpp
        $error("usp_interp: NCOEFFS/UP_FACTOR must be an integer power of two >= 2");
    end
    if (FIXED_COEFFS && (INITIAL_COEFFS == "")) begin : g_bad_rom
        $error("usp_interp: fixed coefficients need an INITIAL_COEFFS file");
    end

    state_t              state_q, state_d;
    logic [TW-1:0]       wptr_q, wptr_d;
    logic [CW-1:0]       tidx_q, tidx_d;
    logic [PW-1:0]       p_q, p_d;
    logic [TW-1:0]       k_q, k_d;
    logic [1:0]          ocnt_q, ocnt_d;

    logic signed [COEFF_W-1:0]  cmem [NCOEFFS];
    logic signed [IN_WIDTH-1:0] dmem [TPP];
    logic signed [COEFF_W-1:0]  c_rd_q;
    logic signed [IN_WIDTH-1:0] d_rd_q;
    logic                       rd_vld_q, rd_first_q, rd_last_q;

    logic                       accept_s, tap_we_s, d_we_s;
    logic [TW-1:0]              d_waddr_s, d_raddr_s;
    logic [IN_WIDTH-1:0]        d_wdata_s;
    logic [CW-1:0]              c_raddr_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic                       sum_vld_s;

    logic                       o_ready_q, o_valid_q;
    logic [OUT_WIDTH-1:0]       o_sample_q;

    assign accept_s  = (state_q == ST_IDLE) && o_ready_q && i_valid;
    assign tap_we_s  = (state_q == ST_IDLE) && i_tap_wr && !FIXED_COEFFS && !i_reset;
    assign d_raddr_s = wptr_q - TW'(1) - k_q;
    assign c_raddr_s = CW'(int'(k_q) * UP_FACTOR + int'(p_q));

    // Next-state, pointer and data-memory write control.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        tidx_d    = tidx_q;
        p_d       = p_q;
        k_d       = k_q;
        ocnt_d    = ocnt_q;
        d_we_s    = 1'b0;
        d_waddr_s = wptr_q;
        d_wdata_s = i_sample;
        case (state_q)
            ST_CLEAR: begin
                d_we_s    = 1'b1;
                d_waddr_s = k_q;
                d_wdata_s = '0;
                if (k_q == TW'(TPP - 1)) begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + TW'(1);
                end
            end
            ST_IDLE: begin
                if (tap_we_s) begin
                    tidx_d = (tidx_q == CW'(NCOEFFS - 1)) ? '0 : tidx_q + CW'(1);
                end else begin
                    tidx_d = tidx_q;
                end
                if (accept_s) begin
                    d_we_s  = 1'b1;
                    wptr_d  = wptr_q + TW'(1);
                    p_d     = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_q == TW'(TPP - 1)) begin
                    k_d     = '0;
                    ocnt_d  = 2'd0;
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + TW'(1);
                end
            end
            ST_OUT: begin
                // The last phase drains one extra cycle so o_ready follows the final o_valid.
                if (p_q != PW'(UP_FACTOR - 1)) begin
                    if (ocnt_q == 2'd1) begin
                        p_d     = p_q + PW'(1);
                        state_d = ST_MAC;
                    end else begin
                        ocnt_d = ocnt_q + 2'd1;
                    end
                end else begin
                    if (ocnt_q == 2'd2) begin
                        state_d = ST_IDLE;
                    end else begin
                        ocnt_d = ocnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_CLEAR;
            wptr_q  <= '0;
            tidx_q  <= '0;
            p_q     <= '0;
            k_q     <= '0;
            ocnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            tidx_q  <= tidx_d;
            p_q     <= p_d;
            k_q     <= k_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Coefficient RAM: tap write port and registered read.
    always_ff @(posedge i_clk) begin
        if (tap_we_s) begin
            cmem[tidx_q] <= i_tap;
        end
        c_rd_q <= cmem[c_raddr_s];
    end

    // Sample delay-line RAM: write port and registered read.
    always_ff @(posedge i_clk) begin
        if (d_we_s) begin
            dmem[d_waddr_s] <= d_wdata_s;
        end
        d_rd_q <= dmem[d_raddr_s];
    end

    // Tap tags travel alongside the registered RAM read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_vld_q   <= (state_q == ST_MAC);
            rd_first_q <= (k_q == TW'(0));
            rd_last_q  <= (k_q == TW'(TPP - 1));
        end
    end

    usp_mac #(
        .A_W   (IN_WIDTH),
        .B_W   (COEFF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i     (i_clk),
        .reset_i   (i_reset),
        .vld_i     (rd_vld_q),
        .first_i   (rd_first_q),
        .last_i    (rd_last_q),
        .a_i       (d_rd_q),
        .b_i       (c_rd_q),
        .sum_o     (sum_s),
        .sum_vld_o (sum_vld_s)
    );

    // Output registers: ready, result strobe and rounded/saturated sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ready_q  <= 1'b0;
            o_valid_q  <= 1'b0;
            o_sample_q <= '0;
        end else begin
            o_ready_q <= (state_d == ST_IDLE);
            o_valid_q <= sum_vld_s;
            if (sum_vld_s) begin
                o_sample_q <= OUT_WIDTH'(sat_round(SAT_W'(sum_s), COEFF_W - 1, OUT_WIDTH));
            end else begin
                o_sample_q <= o_sample_q;
            end
        end
    end

    assign o_ready  = o_ready_q;
    assign o_valid  = o_valid_q;
    assign o_sample = o_sample_q;

endmodule
